// File: rtl/bus_arbiter.sv
// Two-master bus arbiter: last-owner fairness with a per-owner burst limit.
// Read responses are routed to the issuing master one cycle after the address.
module bus_arbiter #(
  parameter int WIDTH     = 32,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             m0_req,
  input  logic [WIDTH-1:0] m0_addr,
  input  logic [WIDTH-1:0] m0_wdata,
  input  logic             m0_we,
  output logic             m0_gnt,
  output logic [WIDTH-1:0] m0_rdata,
  output logic             m0_rvalid,
  input  logic             m1_req,
  input  logic [WIDTH-1:0] m1_addr,
  input  logic [WIDTH-1:0] m1_wdata,
  input  logic             m1_we,
  output logic             m1_gnt,
  output logic [WIDTH-1:0] m1_rdata,
  output logic             m1_rvalid,
  output logic [WIDTH-1:0] bus_addr,
  output logic [WIDTH-1:0] bus_wdata,
  output logic             bus_we,
  input  logic [WIDTH-1:0] bus_rdata
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] MAXB = CW'(MAX_BURST);

  typedef enum logic [1:0] {
    IDLE,
    OWN0,
    OWN1
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;
  logic          last;
  logic          xfer0;
  logic          xfer1;
  logic          burst_done;

  assign xfer0      = (state == OWN0) && m0_req;
  assign xfer1      = (state == OWN1) && m1_req;
  assign burst_done = cnt >= (MAXB - CW'(1));

  assign m0_gnt   = (state == OWN0);
  assign m1_gnt   = (state == OWN1);
  assign m0_rdata = bus_rdata;
  assign m1_rdata = bus_rdata;

  // Next owner: yield on burst limit only when the other master waits.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (m0_req && m1_req)
          state_nx = last ? OWN0 : OWN1;
        else if (m0_req)
          state_nx = OWN0;
        else if (m1_req)
          state_nx = OWN1;
      end
      OWN0: begin
        if (m0_req) begin
          if (burst_done && m1_req)
            state_nx = OWN1;
        end else if (m1_req) begin
          state_nx = OWN1;
        end else begin
          state_nx = IDLE;
        end
      end
      OWN1: begin
        if (m1_req) begin
          if (burst_done && m0_req)
            state_nx = OWN0;
        end else if (m0_req) begin
          state_nx = OWN0;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Burst length: restarts with each new owner, saturates while held.
  always_comb begin
    cnt_nx = cnt;
    if (state_nx != state || state_nx == IDLE)
      cnt_nx = '0;
    else if ((xfer0 || xfer1) && cnt != MAXB)
      cnt_nx = cnt + CW'(1);
  end

  // Bus drives only the active transfer; zeros otherwise.
  always_comb begin
    bus_addr  = '0;
    bus_wdata = '0;
    bus_we    = 1'b0;
    if (xfer0) begin
      bus_addr  = m0_addr;
      bus_wdata = m0_wdata;
      bus_we    = m0_we;
    end else if (xfer1) begin
      bus_addr  = m1_addr;
      bus_wdata = m1_wdata;
      bus_we    = m1_we;
    end
  end

  // State, burst count, fairness pointer and read-response tags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      last      <= 1'b1;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      m0_rvalid <= xfer0 && !m0_we;
      m1_rvalid <= xfer1 && !m1_we;
      if (state == OWN0)
        last <= 1'b0;
      else if (state == OWN1)
        last <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: per-cycle expectations are queued
// by the stimulus and compared by an independent monitor.
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        bus_we;

  typedef struct {
    int          id;
    logic [1:0]  gnt;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [1:0]  rv;
    logic [31:0] rdata;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cnum = 0;
  bit   done = 0;

  always #5 clk = ~clk;

  bus_arbiter #(.WIDTH(32), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_we(m0_we), .m0_gnt(m0_gnt), .m0_rdata(m0_rdata),
    .m0_rvalid(m0_rvalid),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_we(m1_we), .m1_gnt(m1_gnt), .m1_rdata(m1_rdata),
    .m1_rvalid(m1_rvalid),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we),
    .bus_rdata(bus_rdata)
  );

  function automatic void check(string nm, int id,
                                logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, id, act, exp);
    end
  endfunction

  // Monitor: one queued expectation per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("gnt", e.id, {30'd0, m1_gnt, m0_gnt}, {30'd0, e.gnt});
      check("bus_addr", e.id, bus_addr, e.addr);
      check("bus_wdata", e.id, bus_wdata, e.wdata);
      check("bus_we", e.id, {31'd0, bus_we}, {31'd0, e.we});
      check("rvalid", e.id, {30'd0, m1_rvalid, m0_rvalid}, {30'd0, e.rv});
      if (e.rv[0]) check("m0_rdata", e.id, m0_rdata, e.rdata);
      if (e.rv[1]) check("m1_rdata", e.id, m1_rdata, e.rdata);
    end
  end

  task automatic set0(input logic r, input logic w,
                      input logic [31:0] a, input logic [31:0] d);
    m0_req = r; m0_we = w; m0_addr = a; m0_wdata = d;
  endtask

  task automatic set1(input logic r, input logic w,
                      input logic [31:0] a, input logic [31:0] d);
    m1_req = r; m1_we = w; m1_addr = a; m1_wdata = d;
  endtask

  // eg/erv bit 0 = master 0, bit 1 = master 1.
  task automatic cyc(input logic [1:0] eg, input logic [31:0] ea,
                     input logic [31:0] ed, input logic ewe,
                     input logic [1:0] erv);
    exp_t e;
    bus_rdata = $urandom;
    e.id = cnum;
    e.gnt = eg;
    e.addr = ea;
    e.wdata = ed;
    e.we = ewe;
    e.rv = erv;
    e.rdata = bus_rdata;
    q.push_back(e);
    cnum++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bus_rdata = '0;
    set0(0, 0, 0, 0);
    set1(0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    // reset state
    cyc(2'b00, 0, 0, 0, 2'b00);
    // m0 single read at 10
    rst = 1'b0;
    set0(1, 0, 10, 0);
    cyc(2'b00, 0, 0, 0, 2'b00);
    cyc(2'b01, 10, 0, 0, 2'b00);
    set0(0, 0, 10, 0);
    cyc(2'b01, 0, 0, 0, 2'b01);
    cyc(2'b00, 0, 0, 0, 2'b00);
    // m1 write alone
    set1(1, 1, 32'h2000_0000, 12);
    cyc(2'b00, 0, 0, 0, 2'b00);
    cyc(2'b10, 32'h2000_0000, 12, 1, 2'b00);
    cyc(2'b10, 32'h2000_0000, 12, 1, 2'b00);
    set1(0, 1, 32'h2000_0000, 12);
    cyc(2'b10, 0, 0, 0, 2'b00);
    cyc(2'b00, 0, 0, 0, 2'b00);
    // both requesting: 4/4 alternation, m0 first (m1 was last)
    set0(1, 0, 32'h100, 0);
    set1(1, 1, 32'h200, 5);
    cyc(2'b00, 0, 0, 0, 2'b00);
    cyc(2'b01, 32'h100, 0, 0, 2'b00);
    repeat (3) cyc(2'b01, 32'h100, 0, 0, 2'b01);
    cyc(2'b10, 32'h200, 5, 1, 2'b01);
    repeat (3) cyc(2'b10, 32'h200, 5, 1, 2'b00);
    set1(1, 0, 32'h200, 0);
    cyc(2'b01, 32'h100, 0, 0, 2'b00);
    repeat (2) cyc(2'b01, 32'h100, 0, 0, 2'b01);
    // m0 read at 3 on last burst cycle; response follows the switch
    set0(1, 0, 3, 0);
    cyc(2'b01, 3, 0, 0, 2'b01);
    set0(1, 0, 32'h44, 0);
    cyc(2'b10, 32'h200, 0, 0, 2'b01);
    // reset during an m1 read transfer
    rst = 1'b1;
    cyc(2'b10, 32'h200, 0, 0, 2'b10);
    rst = 1'b0;
    cyc(2'b00, 0, 0, 0, 2'b00);
    cyc(2'b01, 32'h44, 0, 0, 2'b00);
    set0(0, 0, 32'h44, 0);
    set1(0, 0, 32'h200, 0);
    cyc(2'b01, 0, 0, 0, 2'b01);
    cyc(2'b00, 0, 0, 0, 2'b00);
    // sole requester keeps the bus past saturation
    set0(1, 1, 32'h50, 7);
    cyc(2'b00, 0, 0, 0, 2'b00);
    repeat (6) cyc(2'b01, 32'h50, 7, 1, 2'b00);
    set1(1, 0, 32'h200, 0);
    cyc(2'b01, 32'h50, 7, 1, 2'b00);
    cyc(2'b10, 32'h200, 0, 0, 2'b00);
    set0(0, 0, 0, 0);
    set1(0, 0, 0, 0);
    cyc(2'b10, 0, 0, 0, 2'b10);
    cyc(2'b00, 0, 0, 0, 2'b00);
    done = 1;
  end

  initial begin
    wait (done);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: stimulus did not complete, expected done");
    $fatal(1);
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, sets address and data width.
REQ-002 Parameter MAX_BURST, default 4, sets the maximum consecutive grant cycles per owner while the other master waits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 m0_req  input  1  master 0 (core data port) requests a bus transfer.
REQ-006 m0_addr  input  WIDTH  master 0 address.
REQ-007 m0_wdata  input  WIDTH  master 0 write data.
REQ-008 m0_we  input  1  master 0 write enable (0 = read).
REQ-009 m0_gnt  output  1  master 0 owns the bus this cycle.
REQ-010 m0_rdata  output  WIDTH  master 0 read data.
REQ-011 m0_rvalid  output  1  m0_rdata valid this cycle.
REQ-012 m1_req, m1_addr, m1_wdata, m1_we, m1_gnt, m1_rdata, m1_rvalid  same directions, widths and meanings for master 1 (loader/DMA).
REQ-013 bus_addr  output  WIDTH  address to bus_interconnect.
REQ-014 bus_wdata  output  WIDTH  write data to bus_interconnect.
REQ-015 bus_we  output  1  write enable to bus_interconnect.
REQ-016 bus_rdata  input  WIDTH  read data from bus_interconnect; valid one cycle after the read address is presented (synchronous RAM/GPIO).

Function
REQ-017 The FSM SHALL have three states: IDLE, OWN0, OWN1; m0_gnt = (state==OWN0), m1_gnt = (state==OWN1), both registered.
REQ-018 A transfer SHALL occur in any cycle where mX_gnt=1 and mX_req=1; only then SHALL bus_addr/bus_wdata/bus_we carry mX values, otherwise bus_addr=0, bus_wdata=0, bus_we=0.
REQ-019 IDLE: only m0_req -> OWN0; only m1_req -> OWN1; both -> the master not granted last (last-owner pointer, reset value 1 so m0 wins first); neither -> stay IDLE.
REQ-020 The first grant SHALL appear the cycle after req is first seen in IDLE (one-cycle arbitration latency).
REQ-021 OWNx with reqx=1: stay OWNx unless burst count reaches MAX_BURST and the other master requests, then go directly to OWNy (no IDLE bubble).
REQ-022 OWNx with reqx=0: go to OWNy if reqy=1, else IDLE.
REQ-023 The burst counter SHALL clear on every ownership change or entry to IDLE, increment on each transfer cycle, and saturate at MAX_BURST.
REQ-024 With only one master requesting, ownership SHALL be held indefinitely (no forced release at saturation).
REQ-025 mX_rvalid SHALL be registered: asserted exactly one cycle after a read transfer (gnt & req & ~we) by mX, with mX_rdata = bus_rdata that cycle.
REQ-026 mX_rdata SHALL pass bus_rdata through at all times; masters use it only when mX_rvalid=1.
REQ-027 A read completing after an ownership switch SHALL still be delivered to the master that issued it, never to the new owner.
REQ-028 Writes SHALL produce no rvalid.
REQ-029 m0_gnt and m1_gnt SHALL never be 1 simultaneously.

Reset
REQ-030 While rst=1 at a clock edge: state=IDLE, burst counter=0, last-owner=1, m0_gnt=m1_gnt=0, m0_rvalid=m1_rvalid=0, bus_we=0.
REQ-031 Reset mid-transfer SHALL drop any pending read (no rvalid the following cycle) and SHALL apply no write.

Verification
REQ-032 Reset, then m0_req=1, m0_addr=10, m0_we=0 -> m0_gnt=1 next cycle, bus_addr=10, bus_we=0; next cycle m0_rvalid=1, m0_rdata=bus_rdata (e.g. 8).
REQ-033 From IDLE, m0_req=m1_req=1 held, MAX_BURST=4 -> m0 granted 4 cycles, then m1 for 4, then m0; grants never overlap.
REQ-034 m1 writes addr 0x2000_0000, wdata 12, while m0 idle -> bus_we=1 only during m1 grant cycles; m1_rvalid stays 0.
REQ-035 m0 read at addr 3 in its last burst cycle with m1 waiting -> m1_gnt next cycle and m0_rvalid=1 (not m1_rvalid) with bus_rdata.
REQ-036 rst=1 during an m1 read grant -> next cycle m1_gnt=0, m1_rvalid=0, bus_we=0, state IDLE; after rst release with both requesting, m0 is granted first.
